// File: rtl/mudi_pkg.sv
// Shared types and helpers for the HI/LO multiply-divide issue path.
// Latency: none (types, constants and pure functions only).
// Backpressure: none; consumers apply the stall rules.
package mudi_pkg;

   // HI/LO op encoding as carried down the pipe and onto the unit interface
   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MFHI  = 3'd6,
      OP_MFLO  = 3'd7
   } hilo_op_t;

   // Which kind of multi-cycle operation the shadow counter is tracking
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mudi_state_t;

   localparam int DEF_MUL_LAT = 5;
   localparam int DEF_DIV_LAT = 10;

   // Ops that occupy the unit for several cycles
   function automatic logic OP_IS_MULDIV(input hilo_op_t op);
      return (op <= OP_DIVU);
   endfunction

   // Single-cycle HI/LO writes, started but never keeping the unit busy
   function automatic logic OP_IS_MT(input hilo_op_t op);
      return (op == OP_MTHI) || (op == OP_MTLO);
   endfunction

endpackage

// File: rtl/mudi_shadow_cnt.sv
// Shadow busy counter, op-kind state machine and sticky busy-mismatch flag.
// Latency: counter/state/flag all update one clock after the start or check.
// Backpressure: none; the counter value drives the stall decode in the parent.
module mudi_shadow_cnt
   import mudi_pkg::*;
#(
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DIV_LAT = DEF_DIV_LAT,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             intReq,
   input  logic             start,
   input  hilo_op_t         op,
   input  logic             busy,
   output logic [CNT_W-1:0] cnt,
   output mudi_state_t      state,
   output logic             busyErr
);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   // Counter and state: an interrupt lets the count drain but parks it at 1,
   // so the D-stage stall keeps holding until the interrupt window closes.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         state <= ST_IDLE;
      end else if (intReq) begin
         if (cnt > ONE) begin
            cnt <= cnt - ONE;
         end
      end else if (start && OP_IS_MULDIV(op)) begin
         if ((op == OP_MULT) || (op == OP_MULTU)) begin
            cnt   <= MUL_LOAD;
            state <= ST_MUL;
         end else begin
            cnt   <= DIV_LOAD;
            state <= ST_DIV;
         end
      end else if (cnt != '0) begin
         cnt <= cnt - ONE;
         if (cnt == ONE) begin
            state <= ST_IDLE;
         end
      end
   end

   // Sticky flag: the unit's busy must mirror the shadow count every cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         busyErr <= 1'b0;
      end else if ((cnt != '0) != busy) begin
         busyErr <= 1'b1;
      end
   end

endmodule

// File: rtl/mudi_issue_ctrl.sv
// E-stage issue control for the HI/LO unit: start decode, operand drive, D-stage stall.
// Latency: start/stall/operands combinational; shadow count and busyErr registered.
// Backpressure: D_stall holds a D-stage HI/LO op until the shadow count drains. Optional stats: MUDI_STATS_EN.
module mudi_issue_ctrl
   import mudi_pkg::*;
#(
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DIV_LAT = DEF_DIV_LAT,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        intReq,
   input  logic        E_valid,
   input  hilo_op_t    E_hiloOp,
   input  logic [31:0] E_rs,
   input  logic [31:0] E_rt,
   input  logic        D_isHilo,
   input  logic        MUDI_isBusy,
   output logic        E_isStart,
   output hilo_op_t    MUDI_mudiOp,
   output logic [31:0] MUDI_src1,
   output logic [31:0] MUDI_src2,
   output logic        D_stall,
   output logic        busyErr
`ifdef MUDI_STATS_EN
   ,
   output logic [31:0] statStall,
   output logic [31:0] statOps
`endif
);

   logic [CNT_W-1:0] cnt;
   mudi_state_t      state;

   // A start is only legal into an idle unit and never for a squashed op;
   // mfhi/mflo read HI/LO directly and never start the unit.
   assign E_isStart = E_valid
                    & (OP_IS_MULDIV(E_hiloOp) | OP_IS_MT(E_hiloOp))
                    & ~intReq
                    & (cnt == '0);

   // Any D-stage HI/LO op waits while the unit is busy or about to become busy;
   // an mthi/mtlo in E completes in one cycle and needs no stall.
   assign D_stall = D_isHilo & ((cnt != '0) | (E_isStart & OP_IS_MULDIV(E_hiloOp)));

   assign MUDI_mudiOp = E_hiloOp;
   assign MUDI_src1   = E_rs;
   assign MUDI_src2   = E_rt;

   mudi_shadow_cnt #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT),
      .CNT_W   (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .intReq  (intReq),
      .start   (E_isStart),
      .op      (E_hiloOp),
      .busy    (MUDI_isBusy),
      .cnt     (cnt),
      .state   (state),
      .busyErr (busyErr)
   );

`ifdef MUDI_STATS_EN
   // Wrapping event counters for stall cycles and issued starts
   always_ff @(posedge clk) begin
      if (reset) begin
         statStall <= '0;
         statOps   <= '0;
      end else begin
         if (D_stall) begin
            statStall <= statStall + 32'd1;
         end
         if (E_isStart) begin
            statOps <= statOps + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mudi_issue_ctrl.sv
// Directed bench for mudi_issue_ctrl: per-cycle stimulus pushes expectations, a monitor pops and checks.
// Latency: expectations describe outputs within the same cycle, before the next rising edge.
// Backpressure: not applicable; the monitor samples every cycle that has a queued expectation.
module tb_mudi_issue_ctrl;
   import mudi_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        intReq;
   logic        E_valid;
   hilo_op_t    E_hiloOp;
   logic [31:0] E_rs;
   logic [31:0] E_rt;
   logic        D_isHilo;
   logic        MUDI_isBusy;
   logic        E_isStart;
   hilo_op_t    MUDI_mudiOp;
   logic [31:0] MUDI_src1;
   logic [31:0] MUDI_src2;
   logic        D_stall;
   logic        busyErr;
`ifdef MUDI_STATS_EN
   logic [31:0] statStall;
   logic [31:0] statOps;
`endif

   always #5 clk = ~clk;

   mudi_issue_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .intReq      (intReq),
      .E_valid     (E_valid),
      .E_hiloOp    (E_hiloOp),
      .E_rs        (E_rs),
      .E_rt        (E_rt),
      .D_isHilo    (D_isHilo),
      .MUDI_isBusy (MUDI_isBusy),
      .E_isStart   (E_isStart),
      .MUDI_mudiOp (MUDI_mudiOp),
      .MUDI_src1   (MUDI_src1),
      .MUDI_src2   (MUDI_src2),
      .D_stall     (D_stall),
      .busyErr     (busyErr)
`ifdef MUDI_STATS_EN
      ,
      .statStall   (statStall),
      .statOps     (statOps)
`endif
   );

   typedef struct packed {
      logic        start;
      logic        stall;
      logic        err;
      logic [3:0]  cnt;
      logic [1:0]  st;
      logic [2:0]  op;
      logic [31:0] s1;
      logic [31:0] s2;
   } exp_t;

   exp_t  q[$];
   string nq[$];
   int    total = 0;
   int    bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   // One clock of stimulus plus the outputs expected before the next edge
   task automatic cyc(input string nm, input logic rst, input logic v, input hilo_op_t op,
                      input logic [31:0] rs, input logic [31:0] rt, input logic dh,
                      input logic ir, input logic bz, input logic xs, input logic xst,
                      input logic xe, input logic [3:0] xc, input mudi_state_t xsta);
      exp_t e;
      @(negedge clk);
      reset       = rst;
      E_valid     = v;
      E_hiloOp    = op;
      E_rs        = rs;
      E_rt        = rt;
      D_isHilo    = dh;
      intReq      = ir;
      MUDI_isBusy = bz;
      e.start = xs;
      e.stall = xst;
      e.err   = xe;
      e.cnt   = xc;
      e.st    = xsta;
      e.op    = op;
      e.s1    = rs;
      e.s2    = rt;
      q.push_back(e);
      nq.push_back(nm);
   endtask

   // Monitor: checks outputs a few ns after the drive point, well before the rising edge
   initial begin
      exp_t  e;
      string n;
      forever begin
         @(negedge clk);
         #3;
         if (q.size() > 0) begin
            e = q.pop_front();
            n = nq.pop_front();
            chk({n, ".start"}, 32'(E_isStart),          32'(e.start));
            chk({n, ".stall"}, 32'(D_stall),            32'(e.stall));
            chk({n, ".err"},   32'(busyErr),            32'(e.err));
            chk({n, ".cnt"},   32'(dut.u_cnt.cnt),      32'(e.cnt));
            chk({n, ".state"}, 32'(dut.u_cnt.state),    32'(e.st));
            chk({n, ".op"},    32'(MUDI_mudiOp),        32'(e.op));
            chk({n, ".src1"},  MUDI_src1,               e.s1);
            chk({n, ".src2"},  MUDI_src2,               e.s2);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; intReq = 1'b0; E_valid = 1'b0; E_hiloOp = OP_MULT;
      E_rs = '0; E_rt = '0; D_isHilo = 1'b0; MUDI_isBusy = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      cyc("rst_state", 0, 0, OP_MFHI, 0, 0, 1, 0, 0,  0, 0, 0, 4'd0, ST_IDLE);

      // mult 3*4 with a HI/LO op waiting in D
      cyc("mul_start", 0, 1, OP_MULT, 32'd3, 32'd4, 1, 0, 0,  1, 1, 0, 4'd0, ST_IDLE);
      for (int i = 1; i <= 5; i++)
         cyc("mul_busy", 0, 0, OP_MULT, 0, 0, 1, 0, 1,  0, 1, 0, 4'(6 - i), ST_MUL);
      cyc("mul_release", 0, 0, OP_MULT, 0, 0, 1, 0, 0,  0, 0, 0, 4'd0, ST_IDLE);

      // divu then ten busy cycles; a stray mtlo while busy must not start
      cyc("divu_start", 0, 1, OP_DIVU, 32'd100, 32'd7, 0, 0, 0,  1, 0, 0, 4'd0, ST_IDLE);
      for (int i = 1; i <= 10; i++)
         cyc("divu_busy", 0, (i == 3), OP_MTLO, 0, 0, 1, 0, 1,  0, 1, 0, 4'(11 - i), ST_DIV);
      cyc("divu_done", 0, 0, OP_MFLO, 0, 0, 1, 0, 0,  0, 0, 0, 4'd0, ST_IDLE);

      // div started, then a 20-cycle interrupt window parks the count at 1
      cyc("div_start", 0, 1, OP_DIV, 32'hFFFF_FFEC, 32'd3, 1, 0, 0,  1, 1, 0, 4'd0, ST_IDLE);
      for (int i = 0; i < 20; i++)
         cyc("div_irq", 0, 1'(i % 2), OP_DIVU, 0, 0, 1, 1, 1,
             0, 1, 0, (i < 9) ? 4'(10 - i) : 4'd1, ST_DIV);
      cyc("div_tail", 0, 0, OP_DIV, 0, 0, 1, 0, 1,  0, 1, 0, 4'd1, ST_DIV);
      cyc("div_done", 0, 0, OP_DIV, 0, 0, 1, 0, 0,  0, 0, 0, 4'd0, ST_IDLE);

      // mthi/mtlo start without stalling; mflo never starts
      cyc("mthi_nostall", 0, 1, OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1, 0, 0,  1, 0, 0, 4'd0, ST_IDLE);
      cyc("mflo_nostart", 0, 1, OP_MFLO, 32'd0, 32'd0, 0, 0, 0,  0, 0, 0, 4'd0, ST_IDLE);
      cyc("mtlo_nostall", 0, 1, OP_MTLO, 32'h1234_5678, 32'd9, 1, 0, 0,  1, 0, 0, 4'd0, ST_IDLE);

      // Interrupt squashes a mult; then a spurious busy sets the sticky error
      cyc("irq_squash", 0, 1, OP_MULT, 32'd5, 32'd6, 1, 1, 0,  0, 0, 0, 4'd0, ST_IDLE);
      cyc("busy_force", 0, 0, OP_MULT, 0, 0, 0, 0, 1,  0, 0, 0, 4'd0, ST_IDLE);
      cyc("err_set",    0, 0, OP_MULT, 0, 0, 0, 0, 0,  0, 0, 1, 4'd0, ST_IDLE);
      cyc("err_sticky", 0, 0, OP_MULT, 0, 0, 0, 0, 0,  0, 0, 1, 4'd0, ST_IDLE);

      // Reset in the middle of a divide at count 7
      cyc("div2_start", 0, 1, OP_DIV, 32'd81, 32'd9, 0, 0, 0,  1, 0, 1, 4'd0, ST_IDLE);
      for (int i = 0; i < 3; i++)
         cyc("div2_busy", 0, 0, OP_DIV, 0, 0, 0, 0, 1,  0, 0, 1, 4'(10 - i), ST_DIV);
      cyc("div2_rst",   1, 0, OP_DIV, 0, 0, 1, 0, 1,  0, 1, 1, 4'd7, ST_DIV);
      cyc("div2_clear", 0, 0, OP_DIV, 0, 0, 1, 0, 0,  0, 0, 0, 4'd0, ST_IDLE);

      repeat (3) @(negedge clk);
      chk("drain", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
